// File: rtl/eth_apb_cfg_sched.sv
// eth_apb_cfg_sched: APB master that programs and services an Ethernet MAC.
// Optional build macro ETH_CFG_READBACK_EN adds a readback after each config write.
module eth_apb_cfg_sched #(
  parameter int TIMEOUT_CYC = 255,
  parameter int MAX_TX_BD   = 128
) (
  input  logic        pclk_i,
  input  logic        prst_i,
  input  logic        cfg_start_i,
  input  logic [31:0] cfg_moder_i,
  input  logic [31:0] cfg_int_mask_i,
  input  logic [7:0]  cfg_tx_bd_num_i,
  input  logic [47:0] cfg_mac_addr_i,
  output logic        cfg_busy_o,
  output logic        cfg_done_o,
  input  logic        int_i,
  output logic        irq_valid_o,
  output logic [31:0] irq_src_o,
  input  logic        usr_req_i,
  input  logic        usr_write_i,
  input  logic [31:0] usr_addr_i,
  input  logic [31:0] usr_wdata_i,
  output logic        usr_ack_o,
  output logic [31:0] usr_rdata_o,
  output logic        err_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] paddr_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i
);

`ifdef ETH_CFG_READBACK_EN
  localparam logic RB_EN = 1'b1;
`else
  localparam logic RB_EN = 1'b0;
`endif

  localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYC - 1);
  localparam logic [7:0] MAX_BD8 = 8'(MAX_TX_BD);

  typedef enum logic [1:0] {
    E_IDLE,
    E_SETUP,
    E_ACCESS
  } eng_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_IRQ_RD,
    S_IRQ_WR,
    S_USR
  } sch_t;

  eng_t        eng_q, eng_d;
  sch_t        sch_q, sch_d;
  logic [9:0]  tcnt_q;
  logic [2:0]  widx_q, widx_d;
  logic        rb_q, rb_d;
  logic [31:0] moder_q, mask_q, src_q;
  logic [7:0]  bd_q;
  logic [47:0] mac_q;
  logic        pend_q, irq_blk_q;

  logic        xfer_ok, xfer_to;
  logic        iss_v, iss_wr;
  logic [31:0] iss_addr, iss_wdata;
  logic        cfg_go, cfg_end, cfg_ok;
  logic        err_d, irq_v_d, irq_end, cap_src;
  logic        usr_ack_d;
  logic [31:0] usr_rd_d;
  logic        adv;
  logic [31:0] c_moder, c_mask;
  logic [7:0]  c_bd;
  logic [47:0] c_mac;

  function automatic logic [31:0] cfg_addr(input logic [2:0] i);
    logic [31:0] a;
    case (i)
      3'd1:    a = 32'h40;
      3'd2:    a = 32'h44;
      3'd3:    a = 32'h20;
      3'd4:    a = 32'h08;
      3'd5:    a = 32'h04;
      default: a = 32'h00;
    endcase
    return a;
  endfunction

  function automatic logic [31:0] cfg_data(
    input logic [2:0]  i,
    input logic [31:0] moder,
    input logic [47:0] mac,
    input logic [7:0]  bd,
    input logic [31:0] mask
  );
    logic [31:0] d;
    case (i)
      3'd0:    d = moder & ~32'h3;
      3'd1:    d = mac[31:0];
      3'd2:    d = {16'h0, mac[47:32]};
      3'd3:    d = {24'h0, bd};
      3'd4:    d = mask;
      3'd5:    d = 32'hFFFF_FFFF;
      default: d = moder;
    endcase
    return d;
  endfunction

  assign xfer_ok   = (eng_q == E_ACCESS) && pready_i;
  assign xfer_to   = (eng_q == E_ACCESS) && !pready_i
                     && (tcnt_q == TO_LAST);
  assign psel_o    = (eng_q != E_IDLE);
  assign penable_o = (eng_q == E_ACCESS);

  // Config values come from the ports on the start cycle, latched after.
  always_comb begin
    c_moder = moder_q;
    c_mask  = mask_q;
    c_bd    = bd_q;
    c_mac   = mac_q;
    if (sch_q == S_IDLE) begin
      c_moder = cfg_moder_i;
      c_mask  = cfg_int_mask_i;
      c_mac   = cfg_mac_addr_i;
      c_bd    = (cfg_tx_bd_num_i > MAX_BD8) ? MAX_BD8 : cfg_tx_bd_num_i;
    end
  end

  // Scheduler next state: picks the next transfer and the completion events.
  always_comb begin
    sch_d     = sch_q;
    widx_d    = widx_q;
    rb_d      = rb_q;
    iss_v     = 1'b0;
    iss_wr    = 1'b0;
    iss_addr  = 32'h0;
    iss_wdata = 32'h0;
    cfg_go    = 1'b0;
    cfg_end   = 1'b0;
    cfg_ok    = 1'b0;
    err_d     = 1'b0;
    irq_v_d   = 1'b0;
    irq_end   = 1'b0;
    cap_src   = 1'b0;
    usr_ack_d = 1'b0;
    usr_rd_d  = 32'h0;
    adv       = 1'b0;
    unique case (sch_q)
      S_IDLE: begin
        if (cfg_start_i || pend_q) begin
          sch_d     = S_CFG;
          widx_d    = 3'd0;
          rb_d      = 1'b0;
          cfg_go    = 1'b1;
          iss_v     = 1'b1;
          iss_wr    = 1'b1;
          iss_addr  = cfg_addr(3'd0);
          iss_wdata = cfg_data(3'd0, c_moder, c_mac, c_bd, c_mask);
        end else if (int_i && !irq_blk_q) begin
          sch_d    = S_IRQ_RD;
          iss_v    = 1'b1;
          iss_addr = 32'h04;
        end else if (usr_req_i && !usr_ack_o) begin
          if (usr_addr_i >= 32'h400) begin
            usr_ack_d = 1'b1;
            err_d     = 1'b1;
          end else begin
            sch_d     = S_USR;
            iss_v     = 1'b1;
            iss_wr    = usr_write_i;
            iss_addr  = usr_addr_i;
            iss_wdata = usr_wdata_i;
          end
        end
      end
      S_CFG: begin
        if (xfer_to) begin
          err_d   = 1'b1;
          cfg_end = 1'b1;
          sch_d   = S_IDLE;
        end else if (xfer_ok) begin
          if (rb_q) begin
            if (prdata_i != cfg_data(widx_q, c_moder, c_mac, c_bd, c_mask)) begin
              err_d   = 1'b1;
              cfg_end = 1'b1;
              sch_d   = S_IDLE;
            end else begin
              adv = 1'b1;
            end
          end else if (RB_EN && widx_q != 3'd5) begin
            rb_d     = 1'b1;
            iss_v    = 1'b1;
            iss_addr = cfg_addr(widx_q);
          end else begin
            adv = 1'b1;
          end
          if (adv) begin
            if (widx_q == 3'd6) begin
              cfg_end = 1'b1;
              cfg_ok  = 1'b1;
              sch_d   = S_IDLE;
            end else begin
              widx_d    = widx_q + 3'd1;
              rb_d      = 1'b0;
              iss_v     = 1'b1;
              iss_wr    = 1'b1;
              iss_addr  = cfg_addr(widx_q + 3'd1);
              iss_wdata = cfg_data(widx_q + 3'd1, c_moder, c_mac, c_bd, c_mask);
            end
          end
        end
      end
      S_IRQ_RD: begin
        if (xfer_to) begin
          err_d   = 1'b1;
          irq_end = 1'b1;
          sch_d   = S_IDLE;
        end else if (xfer_ok) begin
          if (prdata_i != 32'h0) begin
            cap_src   = 1'b1;
            sch_d     = S_IRQ_WR;
            iss_v     = 1'b1;
            iss_wr    = 1'b1;
            iss_addr  = 32'h04;
            iss_wdata = prdata_i;
          end else begin
            irq_end = 1'b1;
            sch_d   = S_IDLE;
          end
        end
      end
      S_IRQ_WR: begin
        if (xfer_to) begin
          err_d   = 1'b1;
          irq_end = 1'b1;
          sch_d   = S_IDLE;
        end else if (xfer_ok) begin
          irq_v_d = 1'b1;
          irq_end = 1'b1;
          sch_d   = S_IDLE;
        end
      end
      S_USR: begin
        if (xfer_to) begin
          err_d     = 1'b1;
          usr_ack_d = 1'b1;
          sch_d     = S_IDLE;
        end else if (xfer_ok) begin
          usr_ack_d = 1'b1;
          usr_rd_d  = pwrite_o ? 32'h0 : prdata_i;
          sch_d     = S_IDLE;
        end
      end
      default: sch_d = S_IDLE;
    endcase
  end

  // APB engine next state; a new SETUP may follow a completing ACCESS.
  always_comb begin
    eng_d = eng_q;
    unique case (eng_q)
      E_IDLE:   if (iss_v) eng_d = E_SETUP;
      E_SETUP:  eng_d = E_ACCESS;
      E_ACCESS: begin
        if (xfer_ok)      eng_d = iss_v ? E_SETUP : E_IDLE;
        else if (xfer_to) eng_d = E_IDLE;
      end
      default:  eng_d = E_IDLE;
    endcase
  end

  // State registers for engine and scheduler.
  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      eng_q  <= E_IDLE;
      sch_q  <= S_IDLE;
      widx_q <= 3'd0;
      rb_q   <= 1'b0;
    end else begin
      eng_q  <= eng_d;
      sch_q  <= sch_d;
      widx_q <= widx_d;
      rb_q   <= rb_d;
    end
  end

  // Bus address/data held from SETUP through ACCESS; ACCESS cycle counter.
  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      paddr_o  <= 32'h0;
      pwdata_o <= 32'h0;
      pwrite_o <= 1'b0;
      tcnt_q   <= 10'd0;
    end else begin
      if (iss_v) begin
        paddr_o  <= iss_addr;
        pwdata_o <= iss_wdata;
        pwrite_o <= iss_wr;
      end
      tcnt_q <= (eng_q == E_ACCESS) ? tcnt_q + 10'd1 : 10'd0;
    end
  end

  // Config latches, status levels and completion pulses.
  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      moder_q     <= 32'h0;
      mask_q      <= 32'h0;
      bd_q        <= 8'h0;
      mac_q       <= 48'h0;
      pend_q      <= 1'b0;
      irq_blk_q   <= 1'b0;
      src_q       <= 32'h0;
      cfg_busy_o  <= 1'b0;
      cfg_done_o  <= 1'b0;
      irq_valid_o <= 1'b0;
      irq_src_o   <= 32'h0;
      usr_ack_o   <= 1'b0;
      usr_rdata_o <= 32'h0;
      err_o       <= 1'b0;
    end else begin
      if (cfg_go) begin
        moder_q <= c_moder;
        mask_q  <= c_mask;
        bd_q    <= c_bd;
        mac_q   <= c_mac;
      end
      pend_q    <= cfg_go ? 1'b0 : (pend_q | (cfg_start_i & ~cfg_busy_o));
      irq_blk_q <= irq_end;
      if (cap_src) src_q <= prdata_i;
      if (cfg_go)       cfg_busy_o <= 1'b1;
      else if (cfg_end) cfg_busy_o <= 1'b0;
      if (cfg_go)      cfg_done_o <= 1'b0;
      else if (cfg_ok) cfg_done_o <= 1'b1;
      irq_valid_o <= irq_v_d;
      if (irq_v_d) irq_src_o <= src_q;
      usr_ack_o <= usr_ack_d;
      if (usr_ack_d) usr_rdata_o <= usr_rd_d;
      err_o <= err_d;
    end
  end

endmodule

// File: tb/tb_eth_apb_cfg_sched.sv
// tb_eth_apb_cfg_sched: directed scoreboard bench for eth_apb_cfg_sched.
// Expected APB transfers and events are queued; a negedge monitor checks them.
module tb_eth_apb_cfg_sched;
  logic        pclk_i = 1'b0;
  logic        prst_i;
  logic        cfg_start_i;
  logic [31:0] cfg_moder_i, cfg_int_mask_i;
  logic [7:0]  cfg_tx_bd_num_i;
  logic [47:0] cfg_mac_addr_i;
  logic        cfg_busy_o, cfg_done_o;
  logic        int_i, irq_valid_o;
  logic [31:0] irq_src_o;
  logic        usr_req_i, usr_write_i;
  logic [31:0] usr_addr_i, usr_wdata_i;
  logic        usr_ack_o;
  logic [31:0] usr_rdata_o;
  logic        err_o;
  logic        psel_o, penable_o, pwrite_o;
  logic [31:0] paddr_o, pwdata_o, prdata_i;
  logic        pready_i;

  logic        stall_en;
  logic [31:0] stall_addr, rdv;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
  } apb_t;

  typedef struct {
    byte         k;
    logic [31:0] d;
    bit          e;
  } evt_t;

  apb_t apb_q[$];
  evt_t evt_q[$];

  eth_apb_cfg_sched dut (
    .pclk_i(pclk_i), .prst_i(prst_i),
    .cfg_start_i(cfg_start_i), .cfg_moder_i(cfg_moder_i),
    .cfg_int_mask_i(cfg_int_mask_i), .cfg_tx_bd_num_i(cfg_tx_bd_num_i),
    .cfg_mac_addr_i(cfg_mac_addr_i), .cfg_busy_o(cfg_busy_o),
    .cfg_done_o(cfg_done_o), .int_i(int_i),
    .irq_valid_o(irq_valid_o), .irq_src_o(irq_src_o),
    .usr_req_i(usr_req_i), .usr_write_i(usr_write_i),
    .usr_addr_i(usr_addr_i), .usr_wdata_i(usr_wdata_i),
    .usr_ack_o(usr_ack_o), .usr_rdata_o(usr_rdata_o),
    .err_o(err_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwrite_o(pwrite_o), .paddr_o(paddr_o), .pwdata_o(pwdata_o),
    .prdata_i(prdata_i), .pready_i(pready_i)
  );

  always #5 pclk_i = ~pclk_i;

  assign pready_i = !(stall_en && psel_o && penable_o
                      && paddr_o == stall_addr);
  assign prdata_i = rdv;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    checks++;
    if ((|{cfg_busy_o, cfg_done_o, irq_valid_o, irq_src_o, usr_ack_o,
           usr_rdata_o, err_o, psel_o, penable_o, pwrite_o,
           paddr_o, pwdata_o}) !== 1'b0) begin
      failures++;
      $display("FAIL %s outputs not all zero psel=%b busy=%b done=%b paddr=%0h",
               name, psel_o, cfg_busy_o, cfg_done_o, paddr_o);
    end
  endtask

  task automatic push_w(input logic [31:0] a, input logic [31:0] d);
    apb_t x;
    x.wr = 1'b1; x.a = a; x.d = d;
    apb_q.push_back(x);
  endtask

  task automatic push_r(input logic [31:0] a);
    apb_t x;
    x.wr = 1'b0; x.a = a; x.d = 32'h0;
    apb_q.push_back(x);
  endtask

  task automatic push_e(input byte k, input logic [31:0] d, input bit e);
    evt_t x;
    x.k = k; x.d = d; x.e = e;
    evt_q.push_back(x);
  endtask

  task automatic push_cfg7();
    push_w(32'h00, 32'h0000_A420);
    push_w(32'h40, 32'h2233_4455);
    push_w(32'h44, 32'h0000_0011);
    push_w(32'h20, 32'h0000_0080);
    push_w(32'h08, 32'h0000_00FF);
    push_w(32'h04, 32'hFFFF_FFFF);
    push_w(32'h00, 32'h0000_A423);
  endtask

  task automatic take(input byte k, input logic [31:0] d, input bit e);
    evt_t x;
    if (evt_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL evt_unexpected kind=%c data=%0h err=%b", k, d, e);
      return;
    end
    x = evt_q.pop_front();
    chk("evt_kind", 64'(k), 64'(x.k));
    chk("evt_data", 64'(d), 64'(x.d));
    chk("evt_err", 64'(e), 64'(x.e));
  endtask

  // Monitor: every completed APB transfer and every output pulse.
  always @(negedge pclk_i) begin
    if (!prst_i) begin
      if (psel_o && penable_o && pready_i) begin
        if (apb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL apb_unexpected addr=%0h wr=%b", paddr_o, pwrite_o);
        end else begin
          apb_t x;
          x = apb_q.pop_front();
          chk("apb_dir", 64'(pwrite_o), 64'(x.wr));
          chk("apb_addr", 64'(paddr_o), 64'(x.a));
          if (x.wr) chk("apb_wdata", 64'(pwdata_o), 64'(x.d));
        end
      end
      if (irq_valid_o) take("I", irq_src_o, 1'b0);
      if (usr_ack_o) take("U", usr_rdata_o, err_o);
      else if (err_o) take("E", 32'h0, 1'b1);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc;
    bit saw;
    prst_i          = 1'b1;
    cfg_start_i     = 1'b0;
    cfg_moder_i     = 32'h0000_A423;
    cfg_int_mask_i  = 32'h0000_00FF;
    cfg_tx_bd_num_i = 8'd200;
    cfg_mac_addr_i  = 48'h0011_2233_4455;
    int_i           = 1'b0;
    usr_req_i       = 1'b0;
    usr_write_i     = 1'b0;
    usr_addr_i      = 32'h0;
    usr_wdata_i     = 32'h0;
    stall_en        = 1'b0;
    stall_addr      = 32'h0;
    rdv             = 32'h0;
    repeat (3) @(posedge pclk_i);
    #1;
    chk_zero("reset_outputs");
    prst_i = 1'b0;

    // Plain config sequence.
    push_cfg7();
    cfg_start_i = 1'b1;
    @(posedge pclk_i); #1;
    cfg_start_i = 1'b0;
    chk("cfg_busy_at_start", 64'(cfg_busy_o), 64'd1);
    chk("cfg_done_at_start", 64'(cfg_done_o), 64'd0);
    n = 0;
    while (!cfg_done_o && n < 40) begin
      @(posedge pclk_i); #1; n++;
    end
    chk("cfg_done_latency", 64'(n), 64'd14);
    chk("cfg_busy_after", 64'(cfg_busy_o), 64'd0);
    chk("cfg_writes_drained", 64'(apb_q.size()), 64'd0);

    // Interrupt with nonzero source.
    rdv = 32'h0000_0005;
    push_r(32'h04);
    push_w(32'h04, 32'h0000_0005);
    push_e("I", 32'h5, 1'b0);
    int_i = 1'b1;
    n = 0;
    while (!irq_valid_o && n < 30) begin
      @(posedge pclk_i); #1; n++;
    end
    int_i = 1'b0;
    chk("irq_pulse_seen", 64'(irq_valid_o), 64'd1);
    repeat (4) @(posedge pclk_i);

    // Interrupt with zero source: read only, no pulse.
    rdv = 32'h0;
    push_r(32'h04);
    int_i = 1'b1;
    @(posedge pclk_i); #1;
    int_i = 1'b0;
    repeat (8) @(posedge pclk_i);
    #1;
    chk("irq_zero_drained", 64'(apb_q.size()), 64'd0);
    chk("irq_zero_no_event", 64'(evt_q.size()), 64'd0);

    // Contention: config, then interrupt, then user write.
    rdv = 32'h0000_0005;
    push_cfg7();
    push_r(32'h04);
    push_w(32'h04, 32'h0000_0005);
    push_e("I", 32'h5, 1'b0);
    push_w(32'h08, 32'h0000_1234);
    push_e("U", 32'h0, 1'b0);
    cfg_start_i = 1'b1;
    int_i       = 1'b1;
    usr_req_i   = 1'b1;
    usr_write_i = 1'b1;
    usr_addr_i  = 32'h08;
    usr_wdata_i = 32'h0000_1234;
    @(posedge pclk_i); #1;
    cfg_start_i = 1'b0;
    n = 0;
    while (usr_req_i && n < 100) begin
      @(posedge pclk_i); #1; n++;
      if (irq_valid_o) int_i = 1'b0;
      if (usr_ack_o) usr_req_i = 1'b0;
    end
    chk("contend_user_acked", 64'(usr_req_i), 64'd0);
    chk("contend_cfg_done", 64'(cfg_done_o), 64'd1);
    int_i = 1'b0;
    usr_req_i = 1'b0;
    repeat (3) @(posedge pclk_i);
    #1;
    chk("contend_drained", 64'(apb_q.size() + evt_q.size()), 64'd0);

    // Timeout on write 3 (MAC_ADDR1).
    stall_en   = 1'b1;
    stall_addr = 32'h44;
    push_w(32'h00, 32'h0000_A420);
    push_w(32'h40, 32'h2233_4455);
    push_e("E", 32'h0, 1'b1);
    cfg_start_i = 1'b1;
    @(posedge pclk_i); #1;
    cfg_start_i = 1'b0;
    acc = 0;
    n = 0;
    while (cfg_busy_o && n < 400) begin
      @(posedge pclk_i); #1; n++;
      if (psel_o && penable_o && paddr_o == 32'h44) acc++;
    end
    chk("timeout_access_cycles", 64'(acc), 64'd255);
    chk("timeout_err_pulse", 64'(err_o), 64'd1);
    chk("timeout_done_low", 64'(cfg_done_o), 64'd0);
    chk("timeout_psel_low", 64'(psel_o), 64'd0);
    stall_en = 1'b0;
    repeat (3) @(posedge pclk_i);
    #1;
    chk("timeout_drained", 64'(apb_q.size() + evt_q.size()), 64'd0);

    // User read of out-of-range address.
    rdv = 32'hDEAD_BEEF;
    push_e("U", 32'h0, 1'b1);
    usr_req_i   = 1'b1;
    usr_write_i = 1'b0;
    usr_addr_i  = 32'h400;
    saw = 1'b0;
    n = 0;
    while (!usr_ack_o && n < 10) begin
      @(posedge pclk_i); #1; n++;
      if (psel_o) saw = 1'b1;
    end
    usr_req_i = 1'b0;
    chk("bad_addr_ack_latency", 64'(n), 64'd1);
    chk("bad_addr_no_psel", 64'(saw), 64'd0);
    chk("bad_addr_err", 64'(err_o), 64'd1);
    chk("bad_addr_rdata", 64'(usr_rdata_o), 64'd0);
    repeat (2) @(posedge pclk_i);

    // User read of MAC_ADDR0.
    rdv = 32'h2233_4455;
    push_r(32'h40);
    push_e("U", 32'h2233_4455, 1'b0);
    usr_req_i  = 1'b1;
    usr_addr_i = 32'h40;
    n = 0;
    while (!usr_ack_o && n < 20) begin
      @(posedge pclk_i); #1; n++;
    end
    usr_req_i = 1'b0;
    chk("user_read_ack", 64'(usr_ack_o), 64'd1);
    chk("user_read_data", 64'(usr_rdata_o), 64'h2233_4455);
    repeat (3) @(posedge pclk_i);

    // Reset during ACCESS of write 5, then restart.
    stall_en   = 1'b1;
    stall_addr = 32'h08;
    push_w(32'h00, 32'h0000_A420);
    push_w(32'h40, 32'h2233_4455);
    push_w(32'h44, 32'h0000_0011);
    push_w(32'h20, 32'h0000_0080);
    cfg_start_i = 1'b1;
    @(posedge pclk_i); #1;
    cfg_start_i = 1'b0;
    saw = 1'b0;
    n = 0;
    while (!saw && n < 60) begin
      @(posedge pclk_i); #1; n++;
      if (psel_o && penable_o && paddr_o == 32'h08) saw = 1'b1;
    end
    chk("reset_mid_reached_w5", 64'(saw), 64'd1);
    prst_i = 1'b1;
    @(posedge pclk_i); #1;
    chk_zero("reset_mid_outputs");
    prst_i   = 1'b0;
    stall_en = 1'b0;
    chk("reset_mid_drained", 64'(apb_q.size()), 64'd0);
    push_cfg7();
    cfg_start_i = 1'b1;
    @(posedge pclk_i); #1;
    cfg_start_i = 1'b0;
    n = 0;
    while (!cfg_done_o && n < 40) begin
      @(posedge pclk_i); #1; n++;
    end
    chk("restart_done_latency", 64'(n), 64'd14);

    repeat (5) @(posedge pclk_i);
    #1;
    chk("final_apb_queue", 64'(apb_q.size()), 64'd0);
    chk("final_evt_queue", 64'(evt_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
